store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Clocking SHALL be one clock, clk; reset SHALL be rst, asynchronous, active-high.
REQ-002 Parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-003 Parameter XLEN, default 64, address and data width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 st_valid  input  1  core presents a store this cycle.
REQ-007 st_addr  input  XLEN  store byte address.
REQ-008 st_data  input  XLEN  store data, lane-aligned to the doubleword.
REQ-009 st_mask  input  8  byte-enable for st_data.
REQ-010 st_ready  output  1  buffer can accept a store; the core stalls when low.
REQ-011 mem_wvalid  output  1  head entry is offered to memory.
REQ-012 mem_waddr  output  XLEN  head doubleword address, with [2:0]=0.
REQ-013 mem_wdata  output  XLEN  head data.
REQ-014 mem_wmask  output  8  head byte-enable.
REQ-015 mem_wready  input  1  memory accepts the head this cycle.
REQ-016 ld_addr  input  XLEN  load lookup address.
REQ-017 ld_hit  output  1  at least one buffered byte matches the ld_addr doubleword.
REQ-018 ld_data  output  XLEN  forwarded bytes, youngest entry wins.
REQ-019 ld_mask  output  8  which bytes of ld_data are valid.
REQ-020 empty  output  1  no entries held.
REQ-021 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-022 The buffer SHALL be an in-order FIFO with head pointer rd_ptr, tail pointer wr_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and a count register.
REQ-023 st_ready SHALL equal (count != DEPTH), decoded from registered state only; it SHALL NOT depend on mem_wready.
REQ-024 An enqueue SHALL occur on a clock edge where st_valid & st_ready; the entry stores {st_addr[XLEN-1:3],3'b0}, st_data and st_mask, and wr_ptr advances.
REQ-025 A dequeue SHALL occur on a clock edge where mem_wvalid & mem_wready; rd_ptr advances.
REQ-026 count SHALL update as follows: enqueue only -> +1; dequeue only -> -1; both -> unchanged; neither -> unchanged.
REQ-027 When full, a simultaneous dequeue SHALL NOT permit an enqueue in the same cycle.
REQ-028 mem_wvalid SHALL equal !empty; mem_waddr, mem_wdata and mem_wmask SHALL come from the head entry and remain stable until accepted.
REQ-029 An entry with st_mask == 0 SHALL be enqueued and drained normally; stores SHALL NOT be coalesced.
REQ-030 Forwarding SHALL be combinational: an entry matches when it is valid and its stored address[XLEN-1:3] equals ld_addr[XLEN-1:3].
REQ-031 For each byte lane, ld_data SHALL take the byte from the youngest matching entry whose mask bit is set; ld_mask SHALL be the OR of the matching masks.
REQ-032 Lanes of ld_data with ld_mask=0 SHALL be 0.
REQ-033 An entry dequeued in the current cycle SHALL still participate in forwarding during that cycle.
REQ-034 A store enqueued in the current cycle SHALL NOT forward until the next cycle.
REQ-035 empty SHALL equal (count == 0).

Reset
REQ-036 On rst, rd_ptr, wr_ptr, count and all entry-valid bits SHALL clear immediately, without waiting for a clock edge.
REQ-037 After reset: st_ready=1, mem_wvalid=0, empty=1, count=0, ld_hit=0, ld_mask=0, ld_data=0.
REQ-038 Reset during operation SHALL discard all pending stores, and mem_wvalid SHALL drop asynchronously.
REQ-039 Entry data and address storage SHALL NOT be reset.

Structure
REQ-040 A shared package SHALL hold XLEN, SB_DEPTH, and an sb_entry_t typedef {addr, data, mask}.
REQ-041 Pointer and count logic SHALL live in one sub-module, sb_fifo_ctrl; entry storage and forwarding SHALL live in store_buffer.

Verification
REQ-042 Reset, then store addr 0x80001004, data 0x11223344_00000000, mask 0xF0 -> next cycle mem_wvalid=1, mem_waddr=0x80001000, mem_wmask=0xF0, count=1.
REQ-043 Hold mem_wready=0 and issue 4 stores -> count=4, st_ready=0; a 5th st_valid is not accepted; a single mem_wready pulse -> count=3 and st_ready=1 the next cycle.
REQ-044 With the buffer full, assert st_valid and mem_wready together -> only the dequeue occurs, count goes 4->3.
REQ-045 Store 0xAA in byte 0 of 0x80002000, then 0xBB in byte 0 plus 0xCC in byte 1 of the same address; ld_addr=0x80002007 -> ld_hit=1, ld_mask=0x03, ld_data[15:0]=0xCCBB.
REQ-046 Assert rst mid-drain with 3 entries held -> mem_wvalid=0 and count=0 before the next edge; ld_hit=0 for any address.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its FIFO control.
package store_buffer_pkg;

  localparam int XLEN     = 64;
  localparam int SB_DEPTH = 4;
  localparam int MASK_W   = 8;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [MASK_W-1:0] mask;
  } sb_entry_t;

  function automatic logic [XLEN-1:0] dword_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Head/tail pointers and occupancy for the store buffer FIFO.
module sb_fifo_ctrl
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic          mem_wready,
  output logic          st_ready,
  output logic          mem_wvalid,
  output logic          enq,
  output logic          deq,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          empty
);

  // Handshakes decode only from registered occupancy, so a full buffer
  // never accepts a store even while the head is draining.
  assign st_ready   = (count != CW'(DEPTH));
  assign empty      = (count == '0);
  assign mem_wvalid = !empty;
  assign enq        = st_valid & st_ready;
  assign deq        = mem_wvalid & mem_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with byte-granular store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int XLEN  = store_buffer_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [XLEN-1:0]            st_addr,
  input  logic [XLEN-1:0]            st_data,
  input  logic [7:0]                 st_mask,
  output logic                       st_ready,
  output logic                       mem_wvalid,
  output logic [XLEN-1:0]            mem_waddr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [7:0]                 mem_wmask,
  input  logic                       mem_wready,
  input  logic [XLEN-1:0]            ld_addr,
  output logic                       ld_hit,
  output logic [XLEN-1:0]            ld_data,
  output logic [7:0]                 ld_mask,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic          enq;
  logic          deq;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;

  sb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .mem_wready (mem_wready),
    .st_ready   (st_ready),
    .mem_wvalid (mem_wvalid),
    .enq        (enq),
    .deq        (deq),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .empty      (empty)
  );

  // Payload storage is deliberately left out of reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr] <= '{addr: dword_align(st_addr), data: st_data, mask: st_mask};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (deq) valid[rd_ptr] <= 1'b0;
      if (enq) valid[wr_ptr] <= 1'b1;
    end
  end

  assign mem_waddr = entries[rd_ptr].addr;
  assign mem_wdata = entries[rd_ptr].data;
  assign mem_wmask = entries[rd_ptr].mask;

  // Walk from oldest to youngest so later matches overwrite earlier lanes.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_data = '0;
    ld_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (valid[idx] && (entries[idx].addr[XLEN-1:3] == ld_addr[XLEN-1:3])) begin
        for (int b = 0; b < 8; b++) begin
          if (entries[idx].mask[b]) begin
            ld_data[8*b +: 8] = entries[idx].data[8*b +: 8];
            ld_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign ld_hit = |ld_mask;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model plus drain monitor.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [7:0]  st_mask;
  logic        st_ready;
  logic        mem_wvalid;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_wready;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic [7:0]  ld_mask;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  sb_entry_t model_q[$];
  sb_entry_t sb_q[$];

  store_buffer #(.DEPTH(DEPTH), .XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_mask    (st_mask),
    .st_ready   (st_ready),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_wready (mem_wready),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .ld_mask    (ld_mask),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs come straight from the queue model: occupancy is its size,
  // forwarding searches it youngest-first per byte lane.
  task automatic checkOutput();
    int          sz;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
    sz       = model_q.size();
    exp_data = '0;
    exp_mask = '0;
    for (int b = 0; b < 8; b++) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (model_q[i].addr[63:3] == ld_addr[63:3] && model_q[i].mask[b]) begin
          exp_data[8*b +: 8] = model_q[i].data[8*b +: 8];
          exp_mask[b]        = 1'b1;
          break;
        end
      end
    end
    chk("count", 64'(count), 64'(sz));
    chk("st_ready", 64'(st_ready), 64'(sz != DEPTH));
    chk("mem_wvalid", 64'(mem_wvalid), 64'(sz != 0));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("ld_mask", 64'(ld_mask), 64'(exp_mask));
    chk("ld_data", ld_data, exp_data);
    chk("ld_hit", 64'(ld_hit), 64'(exp_mask != 0));
  endtask

  task automatic applyStimulus(input logic sv, input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] m, input logic wr, input logic [63:0] la);
    int        sz;
    sb_entry_t e;
    @(negedge clk);
    st_valid   = sv;
    st_addr    = a;
    st_data    = d;
    st_mask    = m;
    mem_wready = wr;
    ld_addr    = la;
    #1;
    checkOutput();
    @(posedge clk);
    sz = model_q.size();
    if (wr && sz != 0) void'(model_q.pop_front());
    if (sv && sz != DEPTH) begin
      e = '{addr: {a[63:3], 3'b000}, data: d, mask: m};
      model_q.push_back(e);
      sb_q.push_back(e);
    end
  endtask

  // Drain monitor: every accepted memory write must match the next expected store.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_wvalid && mem_wready) begin
        if (sb_q.size() == 0) begin
          chk("drain_unexpected", 64'(mem_wvalid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("mem_waddr", mem_waddr, e.addr);
          chk("mem_wdata", mem_wdata, e.data);
          chk("mem_wmask", 64'(mem_wmask), 64'(e.mask));
        end
      end
    end
  end

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 + 64'({$urandom_range(0, 3), 3'b000}) + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    mem_wready = 1'b0; ld_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(0, 0, 0, 0, 0, 64'h8000_1000);

    applyStimulus(1, 64'h8000_1004, 64'h1122_3344_0000_0000, 8'hF0, 0, 64'h8000_1000);
    applyStimulus(0, 0, 0, 0, 0, 64'h8000_1000);
    #1;
    chk("first_waddr", mem_waddr, 64'h8000_1000);
    chk("first_wmask", 64'(mem_wmask), 64'hF0);
    chk("first_count", 64'(count), 64'd1);

    for (int i = 0; i < 3; i++)
      applyStimulus(1, 64'h8000_1100 + 64'(i * 8), {$urandom, $urandom}, 8'(i + 1), 0, 0);
    applyStimulus(1, 64'h8000_1200, 64'hDEAD, 8'hFF, 0, 64'h8000_1200);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    #1;
    chk("pulse_count", 64'(count), 64'd3);
    chk("pulse_ready", 64'(st_ready), 64'd1);

    applyStimulus(1, 64'h8000_1300, 64'h1234, 8'h03, 0, 0);
    applyStimulus(1, 64'h8000_1400, 64'h5678, 8'h0C, 1, 0);
    #1;
    chk("full_both_count", 64'(count), 64'd3);

    repeat (4) applyStimulus(0, 0, 0, 0, 1, 0);

    applyStimulus(1, 64'h8000_2000, 64'h0000_00AA, 8'h01, 0, 0);
    applyStimulus(1, 64'h8000_2000, 64'h0000_CCBB, 8'h03, 0, 64'h8000_2007);
    applyStimulus(0, 0, 0, 0, 0, 64'h8000_2007);
    #1;
    chk("fwd_hit", 64'(ld_hit), 64'd1);
    chk("fwd_mask", 64'(ld_mask), 64'h03);
    chk("fwd_data16", 64'(ld_data[15:0]), 64'hCCBB);

    applyStimulus(1, 64'h8000_2008, 64'h77, 8'h00, 0, 64'h8000_2008);
    applyStimulus(1, 64'h8000_2010, 64'h99, 8'h80, 1, 64'h8000_2000);
    @(negedge clk);
    st_valid = 1'b0; mem_wready = 1'b0; ld_addr = 64'h8000_2000;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_hit", 64'(ld_hit), 64'd0);
    ld_addr = 64'h8000_2010;
    #1;
    chk("rst_hit2", 64'(ld_hit), 64'd0);
    model_q.delete();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 9) < 6), rand_addr(), {$urandom, $urandom},
                    8'($urandom), 1'($urandom_range(0, 1)), rand_addr());

    repeat (DEPTH + 1) applyStimulus(0, 0, 0, 0, 1, rand_addr());
    #5;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
